sr_cmd_arbiter: RTL and testbench

SR_CMD_ARBITER -- requirements
Module: sr_cmd_arbiter

---
 rtl/sr_cmd_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_sr_cmd_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sr_cmd_arbiter
//
// Round-robin arbiter that turns per-requester set/reset/hold/toggle commands
// into one-cycle set (s_out) and reset (r_out) strobes for an external bank of
// SR flip-flops whose current state comes back on q_in.
//
// One command is accepted per cycle and its strobe is driven, registered, in
// the following cycle. A toggle is resolved from q_in when it is accepted, so
// a toggle aimed at the bit currently being strobed would read a stale q. In
// that case the toggle is held off for one STALL cycle and re-arbitrated.
//
// Configuration macro:
//   SR_CMD_ARBITER_TOGGLE_EN  defined   : op 11 toggles the bit, STALL reachable
//                             undefined : op 11 is treated as hold, no STALL,
//                                         stall_cnt is constant zero
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]            command valid per requester
//   req_op     [2*NREQ]          op per requester: 00 hold, 01 reset, 10 set, 11 toggle
//   req_idx    [NREQ*log2 NBITS] target bit index per requester
//   req_ready  [NREQ]            one-hot grant (combinational)
//   q_in       [NBITS]           current q of the SR bank
//   s_out      [NBITS]           registered set strobes
//   r_out      [NBITS]           registered reset strobes
//   stall_cnt  [16]              saturating count of STALL cycles
// -----------------------------------------------------------------------------
module sr_cmd_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [2*NREQ-1:0]               req_op,
    input  logic [NREQ*$clog2(NBITS)-1:0]   req_idx,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NBITS-1:0]                q_in,
    output logic [NBITS-1:0]                s_out,
    output logic [NBITS-1:0]                r_out,
    output logic [15:0]                     stall_cnt
);

    localparam int IW = $clog2(NBITS);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    state_t           state;
    logic [PW-1:0]    ptr;

    logic             win_found;
    logic [PW-1:0]    win;
    op_t              win_op;
    logic [IW-1:0]    win_idx;
    logic             hazard;
    logic             accept;
    logic [NBITS-1:0] s_nxt;
    logic [NBITS-1:0] r_nxt;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        int cand;
        // NOTE: every variable assigned in a combinational block gets a default
        // up front; otherwise paths that skip the assignment infer a latch.
        win_found = 1'b0;
        win       = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win       = PW'(cand);
            end
        end
    end

    assign win_op  = op_t'(req_op[2*int'(win) +: 2]);
    assign win_idx = req_idx[IW*int'(win) +: IW];

`ifdef SR_CMD_ARBITER_TOGGLE_EN
    // A strobe on the target bit this cycle means q_in[win_idx] is about to
    // change, so a toggle resolved from it now would use the old value.
    assign hazard = win_found && (win_op == OP_TOGGLE) &&
                    (s_out[win_idx] || r_out[win_idx]);
`else
    assign hazard = 1'b0;
    logic unused_q;
    assign unused_q = ^q_in;
`endif

    assign accept = win_found && !hazard && (state != STALL);

    // Grant is qualified by rst_n so that it drops the moment reset asserts,
    // not just on the next edge.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n) begin
            req_ready[win] = 1'b1;
        end
    end

    // Strobe pattern for the winning command; only used when it is accepted.
    always_comb begin
        s_nxt = '0;
        r_nxt = '0;
        unique case (win_op)
            OP_SET:   s_nxt[win_idx] = 1'b1;
            OP_RESET: r_nxt[win_idx] = 1'b1;
            OP_TOGGLE: begin
`ifdef SR_CMD_ARBITER_TOGGLE_EN
                s_nxt[win_idx] = ~q_in[win_idx];
                r_nxt[win_idx] =  q_in[win_idx];
`endif
            end
            default: ; // hold: consumed, no strobe
        endcase
    end

    // Control FSM with registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            s_out <= '0;
            r_out <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            s_out <= '0;
            r_out <= '0;
            unique case (state)
                STALL: begin
                    state <= IDLE;
                end
                default: begin
                    if (accept) begin
                        state <= ISSUE;
                        s_out <= s_nxt;
                        r_out <= r_nxt;
                        if (int'(win) == NREQ - 1) begin
                            ptr <= '0;
                        end else begin
                            ptr <= win + PW'(1);
                        end
                    end else if (hazard) begin
                        state <= STALL;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SR_CMD_ARBITER_TOGGLE_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (state == STALL && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_arbiter
//
// Directed scenarios followed by random traffic for sr_cmd_arbiter. A small
// behavioural model (round-robin pick, hazard rule, SR bank) predicts grants,
// strobes and the stall count every cycle. The bench also plays the SR bank:
// q_in follows the strobes the model expects. Honours SR_CMD_ARBITER_TOGGLE_EN.
// -----------------------------------------------------------------------------
module tb_sr_cmd_arbiter;

    localparam int NREQ  = 4;
    localparam int NBITS = 8;
    localparam int IW    = 3;
`ifdef SR_CMD_ARBITER_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_op;
    logic [NREQ*IW-1:0]   req_idx;
    logic [NREQ-1:0]      req_ready;
    logic [NBITS-1:0]     q_in;
    logic [NBITS-1:0]     s_out;
    logic [NBITS-1:0]     r_out;
    logic [15:0]          stall_cnt;

    sr_cmd_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .q_in      (q_in),
        .s_out     (s_out),
        .r_out     (r_out),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         m_ptr;
    bit         m_stall;
    logic [7:0] m_s;
    logic [7:0] m_r;
    logic [7:0] bank;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_stall = 1'b0;
        m_s     = '0;
        m_r     = '0;
        m_cnt   = 0;
    endtask

    // One cycle: drive inputs at the falling edge, compare against the model,
    // then advance the model to what the next rising edge should produce.
    task automatic step(input string tag, input logic [3:0] v,
                        input logic [7:0] op, input logic [11:0] idx);
        logic [3:0] exp_ready;
        logic [7:0] nxt_s;
        logic [7:0] nxt_r;
        bit         nxt_stall;
        int         w;
        int         c;
        int         o;
        int         i;
        @(negedge clk);
        req_valid = v;
        req_op    = op;
        req_idx   = idx;
        q_in      = bank;
        #1;
        exp_ready = '0;
        nxt_s     = '0;
        nxt_r     = '0;
        nxt_stall = 1'b0;
        w         = -1;
        if (!m_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (w < 0 && v[c]) w = c;
            end
        end
        if (w >= 0) begin
            o = int'(op[2*w +: 2]);
            i = int'(idx[IW*w +: IW]);
            if (TOG && o == 3 && (m_s[i] || m_r[i])) begin
                nxt_stall = 1'b1;
            end else begin
                exp_ready[w] = 1'b1;
                m_ptr = (w + 1) % NREQ;
                if (o == 2) nxt_s[i] = 1'b1;
                if (o == 1) nxt_r[i] = 1'b1;
                if (o == 3 && TOG) begin
                    if (bank[i]) nxt_r[i] = 1'b1;
                    else         nxt_s[i] = 1'b1;
                end
            end
        end
        check({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
        check({tag, ".s"},     32'(s_out),     32'(m_s));
        check({tag, ".r"},     32'(r_out),     32'(m_r));
        check({tag, ".cnt"},   32'(stall_cnt), 32'(m_cnt));
        check({tag, ".nolap"}, 32'(s_out & r_out), 32'd0);
        bank = (bank | m_s) & ~m_r;
        if (m_stall && m_cnt < 65535) m_cnt++;
        m_s     = nxt_s;
        m_r     = nxt_r;
        m_stall = nxt_stall;
    endtask

    initial begin
        logic [11:0] ridx;

        bank      = '0;
        q_in      = '0;
        req_valid = 4'b1111;
        req_op    = 8'b10_10_10_10;
        req_idx   = '0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.s",     32'(s_out),     32'd0);
        check("rst.r",     32'(r_out),     32'd0);
        check("rst.cnt",   32'(stall_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Round robin: all four set their own index
        step("rr0", 4'b1111, 8'b10_10_10_10, {3'd3, 3'd2, 3'd1, 3'd0});
        check("rr0.grant", 32'(req_ready), 32'h1);
        step("rr1", 4'b1111, 8'b10_10_10_10, {3'd3, 3'd2, 3'd1, 3'd0});
        check("rr1.grant", 32'(req_ready), 32'h2);
        check("rr1.s",     32'(s_out),     32'h01);
        step("rr2", 4'b1111, 8'b10_10_10_10, {3'd3, 3'd2, 3'd1, 3'd0});
        check("rr2.s",     32'(s_out),     32'h02);
        step("rr3", 4'b1111, 8'b10_10_10_10, {3'd3, 3'd2, 3'd1, 3'd0});
        check("rr3.s",     32'(s_out),     32'h04);
        step("rr4", 4'b1111, 8'b10_10_10_10, {3'd3, 3'd2, 3'd1, 3'd0});
        check("rr4.grant", 32'(req_ready), 32'h1);
        check("rr4.s",     32'(s_out),     32'h08);

        // Set then reset of bit 5 by requester 2
        step("sr0", 4'b0100, 8'b00_10_00_00, {3'd0, 3'd5, 3'd0, 3'd0});
        step("sr1", 4'b0100, 8'b00_01_00_00, {3'd0, 3'd5, 3'd0, 3'd0});
        check("sr1.s", 32'(s_out), 32'h20);
        step("sr2", 4'b0000, 8'b00_00_00_00, 12'd0);
        check("sr2.r", 32'(r_out), 32'h20);
        check("sr2.s", 32'(s_out), 32'h00);
        step("sr3", 4'b0000, 8'b00_00_00_00, 12'd0);

        // Toggle on a bit with a set strobe in flight
        step("hz0", 4'b0001, 8'b00_00_00_10, {3'd0, 3'd0, 3'd0, 3'd1});
        step("hz1", 4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd1, 3'd0});
`ifdef SR_CMD_ARBITER_TOGGLE_EN
        check("hz1.blocked", 32'(req_ready), 32'h0);
`endif
        step("hz2", 4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd1, 3'd0});
        step("hz3", 4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd1, 3'd0});
        step("hz4", 4'b0000, 8'b00_00_00_00, 12'd0);
`ifdef SR_CMD_ARBITER_TOGGLE_EN
        check("hz4.r",   32'(r_out),     32'h02);
        check("hz4.cnt", 32'(stall_cnt), 32'd1);
`endif

        // Op 11 on bit 6 by requester 1
        step("tg0", 4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd6, 3'd0});
        step("tg1", 4'b0000, 8'b00_00_00_00, 12'd0);
`ifndef SR_CMD_ARBITER_TOGGLE_EN
        check("tg1.s",   32'(s_out),     32'h0);
        check("tg1.r",   32'(r_out),     32'h0);
        check("tg1.cnt", 32'(stall_cnt), 32'h0);
`endif

        // Random traffic; indices kept to 0..3 so hazards are frequent
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                ridx[IW*k +: IW] = 3'($urandom_range(0, 3));
            end
            step("rnd", 4'($urandom), 8'($urandom), ridx);
        end

`ifdef SR_CMD_ARBITER_TOGGLE_EN
        // Saturation: preload the counter near its ceiling to keep run time
        // bounded, then keep a continuous toggle hazard going.
        force dut.stall_cnt_q = 16'hFFFC;
        #1 release dut.stall_cnt_q;
        m_cnt = 32'hFFFC;
        check("sat.preload", 32'(stall_cnt), 32'hFFFC);
        for (int n = 0; n < 30; n++) begin
            step("sat", 4'b0010, 8'b00_00_11_00, {3'd0, 3'd0, 3'd1, 3'd0});
        end
        check("sat.hold", 32'(stall_cnt), 32'hFFFF);
`endif

        // Reset in the middle of a strobe on bit 3
        step("mr0", 4'b1000, 8'b10_00_00_00, {3'd3, 3'd0, 3'd0, 3'd0});
        step("mr1", 4'b0000, 8'b00_00_00_00, 12'd0);
        check("mr1.s", 32'(s_out), 32'h08);
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        check("mr.s",     32'(s_out),     32'd0);
        check("mr.r",     32'(r_out),     32'd0);
        check("mr.cnt",   32'(stall_cnt), 32'd0);
        check("mr.ready", 32'(req_ready), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step("mr2", 4'b1111, 8'b10_10_10_10, {3'd3, 3'd2, 3'd1, 3'd0});
        check("mr2.grant", 32'(req_ready), 32'h1);
        step("mr3", 4'b0000, 8'b00_00_00_00, 12'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
